spectrum_ram_arbiter: RTL
=========================

// Module: spectrum_ram_arbiter
// PURPOSE
//  Shares port A of the 64KB system RAM between the Z80 and the ESP32 SPI loader.
//  SPI reads/writes are queued in a small FIFO and served in cycles the CPU does not use.
//  During a load, the CPU is stalled by wait_n, and SPI gets every cycle.
//  The block sits between tv80n/spirw_slave_v and the dpram; it runs entirely on clk.
// PARAMETERS
//  ADDR_W      16  RAM address width
//  DATA_W      8   RAM data width
//  FIFO_DEPTH  4   SPI request FIFO entries; must be a power of 2 and >= 2
// PORTS
//  clk         in   1       system clock; all logic on rising edge
//  reset_n     in   1       synchronous, active-low reset
//  loading     in   1       load mode (cpu control reg bit 1)
//  cpu_slot    in   1       1-clk pulse marking a CPU access opportunity
//  cpu_mreq    in   1       CPU memory request, sampled with cpu_slot
//  cpu_we      in   1       CPU write (1) / read (0)
//  cpu_addr    in   ADDR_W  CPU address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_rdata   out  DATA_W  last CPU read data; held between reads
//  cpu_wait_n  out  1       0 = stall CPU
//  spi_wr      in   1       1-clk pulse: queue write spi_addr <= spi_wdata
//  spi_rd      in   1       1-clk pulse: queue read of spi_addr
//  spi_addr    in   ADDR_W  SPI address
//  spi_wdata   in   DATA_W  SPI write data
//  spi_rdata   out  DATA_W  SPI read result
//  spi_rvalid  out  1       1-clk pulse: spi_rdata updated
//  spi_full    out  1       FIFO holds FIFO_DEPTH entries
//  spi_ovf     out  1       sticky: an SPI request was dropped
//  ram_we      out  1       RAM write enable, registered
//  ram_addr    out  ADDR_W  RAM address, registered
//  ram_din     out  DATA_W  RAM write data, registered
//  ram_dout    in   DATA_W  RAM read data; valid 1 clk after address is presented
// BEHAVIOUR
//  Reset values (reset_n=0 at an edge):
//   ram_we=0, ram_addr=0, ram_din=0, cpu_rdata=8'hFF, spi_rdata=0, spi_rvalid=0.
//   spi_full=0, spi_ovf=0, cpu_wait_n=1. FIFO is emptied and pipeline tags become NONE.
//  Reset mid-operation:
//   A command already on ram_* at that edge completes in the RAM.
//   Its read data is discarded.
//  FIFO push:
//   spi_wr pushes {W,addr,data}; spi_rd pushes {R,addr}.
//   If spi_wr and spi_rd occur together, the write is pushed, the read is dropped, and spi_ovf is set.
//   A push while full is dropped and sets spi_ovf. spi_ovf clears only on reset.
//   A push and a pop in the same cycle are both legal, including when full.
//   The count stays constant in that case.
//  Arbitration in cycle N, one grant per cycle:
//   1) If cpu_slot & cpu_mreq & !loading, grant CPU.
//   2) Else, if the FIFO is not empty, pop the head and grant SPI.
//   3) Else, grant nothing.
//   The CPU always wins a contested cycle; SPI waits with no starvation counter.
//  Issue:
//   ram_addr/ram_din/ram_we take the granted request at the edge ending cycle N.
//   ram_we=1 only for a granted write, and for exactly one cycle.
//   With no grant, ram_we=0 and ram_addr/ram_din hold their values.
//  Read return:
//   A tag pipeline {NONE,CPU,SPI} tracks each read for 2 stages.
//   ram_dout is captured at the end of cycle N+2.
//   For a CPU read, cpu_rdata updates in N+3.
//   For an SPI read, spi_rdata updates and spi_rvalid=1 in N+3.
//   Reads are returned in issue order.
//  cpu_wait_n:
//   Goes to 0 at the edge after loading rises.
//   Returns to 1 only when loading=0, the FIFO is empty, and no SPI tag is in flight.
//   This drains every queued load write before the CPU resumes.
//  No address arithmetic is done; addresses pass through unchanged with no wrap handling.
// TESTING
//  T1 CPU write:
//   cpu_slot, we=1, addr=16'h4000, data=8'hA5.
//   Next cycle: ram_we=1, ram_addr=4000, ram_din=A5. The cycle after: ram_we=0.
//  T2 Contention:
//   In the same cycle, cpu_slot read 16'h0000 and spi_wr 16'h5000/8'h3C.
//   The CPU is issued first; the SPI write is on ram_* one cycle later.
//   cpu_rdata = RAM[0] in N+3.
//  T3 Overflow:
//   With loading=0, no pops, and cpu_slot held each cycle, push 5 spi_wr.
//   spi_full=1 after the 4th push; the 5th push is dropped; spi_ovf=1 and remains 1.
//  T4 Load drain:
//   loading=1, then 3 spi_wr, then loading=0.
//   cpu_wait_n=0 until all 3 writes have appeared on ram_we, then returns to 1.
//   The CPU is never granted meanwhile.
//  T5 SPI read:
//   spi_rd 16'h8001 with RAM[8001]=8'h77 and no CPU traffic.
//   spi_rvalid pulses once with spi_rdata=77, 3 cycles after the grant.
//  T6 Reset mid-op:
//   Queue 2 SPI reads, then pull reset_n=0 after the first grant.
//   No spi_rvalid occurs; the FIFO is empty; all outputs take their reset values.

Source files
------------

// File: rtl/spectrum_ram_arbiter.sv
// Shares RAM port A between the Z80 and the SPI loader; CPU wins contested slots, SPI is queued.
// Latency: grant->ram_* 1 clk, read data back 3 clk; backpressure: spi_full flag, drops set spi_ovf, wait_n stalls CPU.
module spectrum_ram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              loading,
  input  logic              cpu_slot,
  input  logic              cpu_mreq,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_wait_n,
  input  logic              spi_wr,
  input  logic              spi_rd,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_wdata,
  output logic [DATA_W-1:0] spi_rdata,
  output logic              spi_rvalid,
  output logic              spi_full,
  output logic              spi_ovf,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } spi_req_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_SPI  = 2'd2
  } tag_t;

  spi_req_t         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  spi_req_t head;
  spi_req_t push_req_dat;
  logic     fifo_empty;
  logic     cpu_grant;
  logic     spi_grant;
  logic     push_req;
  logic     push_ok;
  logic     push_drop;

  tag_t tag0;
  tag_t tag1;

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_comb begin
    fifo_empty        = (count == '0);
    spi_full          = (count == FULL_CNT);
    head              = fifo_mem[rd_ptr];
    cpu_grant         = cpu_slot & cpu_mreq & ~loading;
    spi_grant         = ~cpu_grant & ~fifo_empty;
    push_req          = spi_wr | spi_rd;
    push_ok           = push_req & (~spi_full | spi_grant);
    push_drop         = (push_req & ~push_ok) | (spi_wr & spi_rd);
    push_req_dat.we   = spi_wr;
    push_req_dat.addr = spi_addr;
    push_req_dat.data = spi_wdata;
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= push_req_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      spi_ovf <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (spi_grant) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, spi_grant})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (push_drop) begin
        spi_ovf <= 1'b1;
      end
    end
  end

  // With no grant the address/data hold so the RAM sees a stable bus.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      tag0     <= TAG_NONE;
      tag1     <= TAG_NONE;
    end else begin
      if (cpu_grant) begin
        ram_we   <= cpu_we;
        ram_addr <= cpu_addr;
        ram_din  <= cpu_wdata;
      end else if (spi_grant) begin
        ram_we   <= head.we;
        ram_addr <= head.addr;
        ram_din  <= head.data;
      end else begin
        ram_we   <= 1'b0;
      end
      if (cpu_grant && !cpu_we) begin
        tag0 <= TAG_CPU;
      end else if (spi_grant && !head.we) begin
        tag0 <= TAG_SPI;
      end else begin
        tag0 <= TAG_NONE;
      end
      tag1 <= tag0;
    end
  end

  // tag1 lines up with the cycle in which ram_dout is valid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cpu_rdata  <= {DATA_W{1'b1}};
      spi_rdata  <= '0;
      spi_rvalid <= 1'b0;
    end else begin
      spi_rvalid <= (tag1 == TAG_SPI);
      if (tag1 == TAG_CPU) begin
        cpu_rdata <= ram_dout;
      end
      if (tag1 == TAG_SPI) begin
        spi_rdata <= ram_dout;
      end
    end
  end

  // The CPU resumes only once every queued load request has left the arbiter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cpu_wait_n <= 1'b1;
    end else if (loading) begin
      cpu_wait_n <= 1'b0;
    end else if (fifo_empty && (tag0 != TAG_SPI) && (tag1 != TAG_SPI)) begin
      cpu_wait_n <= 1'b1;
    end
  end

endmodule
